// File: rtl/coarse_track.sv
// ============================================================================
// Module   : coarse_track
// Purpose  : CDU coarse loop digital half. It holds the 16-bit read counter,
//            decodes the counter into the active-low switch drives, and slews
//            the counter until the coarse error clears.
// Options  : `define COARSE_AMBIG_FLIP_EN makes ambiguity flip the counter by
//            half a turn.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module coarse_track #(
  parameter int SETTLE   = 8,
  parameter int SLEW_DIV = 4,
  parameter int STEP     = 512,
  parameter int LOCK_CNT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coarse_en,
  input  logic        _TLC1H,
  input  logic        _ADHI,
  input  logic        slew_dir,
  input  logic        fine_up,
  input  logic        fine_dn,
  output logic [15:0] cnt,
  output logic        locked,
  output logic        slew_up,
  output logic        slew_dn,
  output logic [12:1] _DC
);

  localparam int TW = $clog2(SETTLE + 1);
  localparam int DW = (SLEW_DIV > 0) ? $clog2(SLEW_DIV + 1) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);

  localparam logic [TW-1:0] c_settle   = TW'(SETTLE);
  localparam logic [TW-1:0] c_t_one    = TW'(1);
  localparam logic [DW-1:0] c_div      = DW'(SLEW_DIV);
  localparam logic [DW-1:0] c_d_one    = DW'(1);
  localparam logic [LW-1:0] c_lock     = LW'(LOCK_CNT);
  localparam logic [LW-1:0] c_lock_m1  = LW'(LOCK_CNT - 1);
  localparam logic [LW-1:0] c_l_one    = LW'(1);
  localparam logic [15:0]   c_step     = 16'(STEP);
  localparam logic [15:0]   c_nstep    = 16'd0 - 16'(STEP);
  localparam logic [15:0]   c_half     = 16'h8000;

  localparam logic [1:0] S_SETTLE = 2'd0;
  localparam logic [1:0] S_SAMPLE = 2'd1;
  localparam logic [1:0] S_SLEW   = 2'd2;
  localparam logic [1:0] S_FLIP   = 2'd3;

  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_div;
  logic [LW-1:0] r_lock_cnt;
  logic [15:0]   r_cnt;
  logic          r_locked;
  logic          r_slew_up;
  logic          r_slew_dn;
  logic [12:1]   r_dc;

  logic          w_flip_req;
  logic [15:0]   w_fine;
  logic [15:0]   w_coarse;
  logic [8:1]    w_oct_low;
  logic [12:1]   w_dc;

`ifdef COARSE_AMBIG_FLIP_EN
  assign w_flip_req = _ADHI;
`else
  // Ambiguity is ignored here; an ambiguous null is resolved by slewing.
  assign w_flip_req = 1'b0 & _ADHI;
`endif

  always_comb begin
    w_fine = 16'd0;
    case ({fine_up, fine_dn})
      2'b10:   w_fine = 16'd1;
      2'b01:   w_fine = 16'hFFFF;
      default: w_fine = 16'd0;
    endcase
  end

  always_comb begin
    w_coarse = 16'd0;
    if (coarse_en) begin
      if (r_state == S_SLEW && r_div == '0)
        w_coarse = slew_dir ? c_step : c_nstep;
      else if (r_state == S_FLIP)
        w_coarse = c_half;
    end
  end

  // Octant selects which pair of sine/cosine switches closes.
  always_comb begin
    w_oct_low = 8'b0000_0000;
    case (r_cnt[15:13])
      3'd0: w_oct_low = 8'b1000_0010;
      3'd1: w_oct_low = 8'b0100_0001;
      3'd2: w_oct_low = 8'b0001_0001;
      3'd3: w_oct_low = 8'b0010_0010;
      3'd4: w_oct_low = 8'b0010_1000;
      3'd5: w_oct_low = 8'b0001_0100;
      3'd6: w_oct_low = 8'b0100_0100;
      default: w_oct_low = 8'b1000_1000;
    endcase
  end

  assign w_dc = {~r_cnt[9], ~r_cnt[10], ~r_cnt[11], ~r_cnt[12], ~w_oct_low};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_SETTLE;
      r_timer    <= c_settle;
      r_div      <= '0;
      r_lock_cnt <= '0;
      r_cnt      <= 16'd0;
      r_locked   <= 1'b0;
      r_slew_up  <= 1'b0;
      r_slew_dn  <= 1'b0;
      r_dc       <= 12'hFFF;
    end else begin
      r_cnt     <= r_cnt + w_fine + w_coarse;
      r_dc      <= w_dc;
      r_slew_up <= 1'b0;
      r_slew_dn <= 1'b0;
      if (!coarse_en) begin
        r_state    <= S_SETTLE;
        r_timer    <= c_settle;
        r_locked   <= 1'b0;
        r_lock_cnt <= '0;
      end else begin
        case (r_state)
          S_SETTLE: begin
            if (r_timer <= c_t_one) begin
              r_timer <= '0;
              r_state <= S_SAMPLE;
            end else begin
              r_timer <= r_timer - c_t_one;
            end
          end
          S_SAMPLE: begin
            if (w_flip_req) begin
              r_state <= S_FLIP;
            end else if (!_TLC1H) begin
              r_lock_cnt <= '0;
              r_locked   <= 1'b0;
              r_div      <= c_div;
              r_state    <= S_SLEW;
            end else if (r_lock_cnt < c_lock) begin
              r_lock_cnt <= r_lock_cnt + c_l_one;
              if (r_lock_cnt == c_lock_m1)
                r_locked <= 1'b1;
            end
          end
          S_SLEW: begin
            // The step itself is applied through w_coarse on this cycle.
            if (r_div == '0) begin
              r_slew_up <= slew_dir;
              r_slew_dn <= ~slew_dir;
              r_timer   <= c_settle;
              r_state   <= S_SETTLE;
            end else begin
              r_div <= r_div - c_d_one;
            end
          end
          default: begin
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
            r_timer    <= c_settle;
            r_state    <= S_SETTLE;
          end
        endcase
      end
    end
  end

  assign cnt     = r_cnt;
  assign locked  = r_locked;
  assign slew_up = r_slew_up;
  assign slew_dn = r_slew_dn;
  assign _DC     = r_dc;

endmodule

`default_nettype wire

// File: tb/tb_coarse_track.sv
// ============================================================================
// Module   : tb_coarse_track
// Purpose  : Directed self-checking bench for coarse_track (default parameters).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_coarse_track;

  logic        clk = 1'b0;
  logic        rst;
  logic        coarse_en;
  logic        tlc1h_n;
  logic        adhi;
  logic        slew_dir;
  logic        fine_up;
  logic        fine_dn;
  logic [15:0] cnt;
  logic        locked;
  logic        slew_up;
  logic        slew_dn;
  logic [12:1] dc;

  int n_cmp = 0;
  int n_err = 0;

  coarse_track dut (
    .clk       (clk),
    .rst       (rst),
    .coarse_en (coarse_en),
    ._TLC1H    (tlc1h_n),
    ._ADHI     (adhi),
    .slew_dir  (slew_dir),
    .fine_up   (fine_up),
    .fine_dn   (fine_dn),
    .cnt       (cnt),
    .locked    (locked),
    .slew_up   (slew_up),
    .slew_dn   (slew_dn),
    ._DC       (dc)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    coarse_en = 1'b1; tlc1h_n = 1'b1; adhi = 1'b0; slew_dir = 1'b0;
    fine_up = 1'b0; fine_dn = 1'b0;
    do_reset();
    n_cmp++; if (cnt !== 16'h0000) begin n_err++; $display("FAIL reset_cnt got %h want 0000", cnt); end
    n_cmp++; if (dc !== 12'hFFF) begin n_err++; $display("FAIL reset_dc got %h want FFF", dc); end
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b want 0", locked); end
    n_cmp++; if ({slew_up, slew_dn} !== 2'b00) begin n_err++; $display("FAIL reset_slew got %b want 00", {slew_up, slew_dn}); end
    tick(1);
    n_cmp++; if (dc !== 12'hF7D) begin n_err++; $display("FAIL first_decode got %h want F7D", dc); end
  endtask

  // Continues straight from the reset release: lock lands on edge 24.
  task automatic test_lock;
    tick(22);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL lock_early got %b want 0 at edge 23", locked); end
    tick(1);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_time got %b want 1 at edge 24", locked); end
  endtask

  task automatic test_slew_up;
    tlc1h_n = 1'b0; slew_dir = 1'b1;
    tick(1);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL err_clears_lock got %b want 0", locked); end
    tick(4);
    n_cmp++; if (cnt !== 16'h0000) begin n_err++; $display("FAIL slew_early got %h want 0000", cnt); end
    tick(1);
    n_cmp++; if (cnt !== 16'h0200) begin n_err++; $display("FAIL slew_step1 got %h want 0200", cnt); end
    n_cmp++; if (slew_up !== 1'b1) begin n_err++; $display("FAIL slew_up_pulse1 got %b want 1", slew_up); end
    tick(1);
    n_cmp++; if (slew_up !== 1'b0) begin n_err++; $display("FAIL slew_up_width got %b want 0", slew_up); end
    tick(13);
    for (int k = 2; k <= 5; k++) begin
      n_cmp++; if (cnt !== 16'(k * 512) || slew_up !== 1'b1) begin
        n_err++; $display("FAIL slew_step%0d got cnt=%h up=%b want cnt=%h up=1", k, cnt, slew_up, 16'(k * 512));
      end
      if (k < 5) tick(14);
    end
    tlc1h_n = 1'b1;
    tick(23);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL relock_early got %b want 0", locked); end
    tick(1);
    n_cmp++; if (locked !== 1'b1 || cnt !== 16'h0A00) begin
      n_err++; $display("FAIL relock got locked=%b cnt=%h want locked=1 cnt=0A00", locked, cnt);
    end
    n_cmp++; if (dc !== 12'h57D) begin n_err++; $display("FAIL decode_0A00 got %h want 57D", dc); end
  endtask

  task automatic test_lock_persist;
    fine_up = 1'b1;
    tick(1);
    fine_up = 1'b0;
    n_cmp++; if (cnt !== 16'h0A01 || locked !== 1'b1) begin
      n_err++; $display("FAIL fine_keeps_lock got cnt=%h locked=%b want 0A01/1", cnt, locked);
    end
  endtask

  task automatic test_wrap;
    tlc1h_n = 1'b0; slew_dir = 1'b0;
    do_reset();
    tick(14);
    n_cmp++; if (cnt !== 16'hFE00 || slew_dn !== 1'b1 || slew_up !== 1'b0) begin
      n_err++; $display("FAIL slew_down got cnt=%h up=%b dn=%b want FE00/0/1", cnt, slew_up, slew_dn);
    end
    slew_dir = 1'b1;
    tick(14);
    n_cmp++; if (cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_up got %h want 0000", cnt); end
    slew_dir = 1'b0;
    tick(14);
    n_cmp++; if (cnt !== 16'hFE00) begin n_err++; $display("FAIL wrap_down got %h want FE00", cnt); end
    slew_dir = 1'b1;
    tick(13);
    fine_up = 1'b1;
    tick(1);
    fine_up = 1'b0;
    n_cmp++; if (cnt !== 16'h0001 || slew_up !== 1'b1) begin
      n_err++; $display("FAIL wrap_plus_fine got cnt=%h up=%b want 0001/1", cnt, slew_up);
    end
  endtask

  task automatic test_ambig;
    logic [15:0] exp_cnt;
    logic        exp_up;
`ifdef COARSE_AMBIG_FLIP_EN
    exp_cnt = 16'h9234; exp_up = 1'b0;
`else
    exp_cnt = 16'h1434; exp_up = 1'b1;
`endif
    coarse_en = 1'b0; tlc1h_n = 1'b0; adhi = 1'b0; slew_dir = 1'b1;
    do_reset();
    fine_up = 1'b1;
    tick(16'h1234);
    fine_up = 1'b0;
    n_cmp++; if (cnt !== 16'h1234 || locked !== 1'b0) begin
      n_err++; $display("FAIL fine_while_disabled got cnt=%h locked=%b want 1234/0", cnt, locked);
    end
    coarse_en = 1'b1; adhi = 1'b1;
    tick(14);
    n_cmp++; if (cnt !== exp_cnt || slew_up !== exp_up || slew_dn !== 1'b0) begin
      n_err++; $display("FAIL ambig got cnt=%h up=%b dn=%b want %h/%b/0", cnt, slew_up, slew_dn, exp_cnt, exp_up);
    end
    adhi = 1'b0;
  endtask

  task automatic test_fine;
    coarse_en = 1'b1; tlc1h_n = 1'b0; slew_dir = 1'b1;
    do_reset();
    tick(11);
    coarse_en = 1'b0; fine_up = 1'b1;
    tick(1);
    fine_up = 1'b0;
    n_cmp++; if (cnt !== 16'h0001 || locked !== 1'b0) begin
      n_err++; $display("FAIL disable_mid_slew got cnt=%h locked=%b want 0001/0", cnt, locked);
    end
    tick(8);
    n_cmp++; if (cnt !== 16'h0001 || slew_up !== 1'b0) begin
      n_err++; $display("FAIL no_step_disabled got cnt=%h up=%b want 0001/0", cnt, slew_up);
    end
    fine_up = 1'b1; fine_dn = 1'b1;
    tick(1);
    n_cmp++; if (cnt !== 16'h0001) begin n_err++; $display("FAIL fine_cancel got %h want 0001", cnt); end
    fine_up = 1'b0;
    tick(1);
    n_cmp++; if (cnt !== 16'h0000) begin n_err++; $display("FAIL fine_dn got %h want 0000", cnt); end
    tick(1);
    fine_dn = 1'b0;
    n_cmp++; if (cnt !== 16'hFFFF) begin n_err++; $display("FAIL fine_dn_wrap got %h want FFFF", cnt); end
    coarse_en = 1'b1;
    tick(13);
    n_cmp++; if (cnt !== 16'hFFFF) begin n_err++; $display("FAIL reenable_settle got %h want FFFF", cnt); end
    tick(1);
    n_cmp++; if (cnt !== 16'h01FF || slew_up !== 1'b1) begin
      n_err++; $display("FAIL reenable_step got cnt=%h up=%b want 01FF/1", cnt, slew_up);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_slew_up();
    test_lock_persist();
    test_wrap();
    test_ambig();
    test_fine();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
